// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes, initiator state encoding and
// a strobe-width helper.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AWPROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } init_state_t;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axilite_chan_src.sv
// Single valid/ready source: captures a payload on load, holds valid until the
// handshake, then remembers that the beat was sent.
module axilite_chan_src #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_payload,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_payload,
    output logic         o_sent,
    output logic         o_fire
);

    logic         r_valid;
    logic         r_sent;
    logic [W-1:0] r_payload;

    assign o_fire    = r_valid && i_ready;
    assign o_valid   = r_valid;
    assign o_payload = r_payload;
    assign o_sent    = r_sent;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_sent    <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_payload <= i_payload;
            r_valid   <= 1'b1;
            r_sent    <= 1'b0;
        end else if (o_fire) begin
            // payload is left untouched so the bus sees a stable value afterwards
            r_valid <= 1'b0;
            r_sent  <= 1'b1;
        end
    end

endmodule

// File: rtl/axilite_write_initiator.sv
// AXI4-Lite write manager: takes one local request, issues AW and W
// independently, waits for B and reports completion with a one-cycle done pulse.
module axilite_write_initiator
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_data,
    input  logic [DATA_WIDTH/8-1:0] i_req_strb,
    output logic                    o_done,
    output logic [1:0]              o_done_resp,
    output logic                    o_busy,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [2:0]              o_awprot,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready
);

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
    localparam int W_PAYLOAD  = DATA_WIDTH + STRB_WIDTH;

    init_state_t      r_state;
    logic             r_req_ready;
    logic             r_bready;
    logic             r_done;
    logic             r_busy;
    logic [1:0]       r_done_resp;

    logic             w_accept;
    logic             w_aw_fire;
    logic             w_aw_sent;
    logic             w_w_fire;
    logic             w_w_sent;
    logic             w_aw_fin;
    logic             w_w_fin;
    logic             w_b_fire;
    logic [W_PAYLOAD-1:0] w_w_payload;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && i_req_valid;
    // a channel counts as finished if it completed earlier or completes on this edge
    assign w_aw_fin = w_aw_sent || w_aw_fire;
    assign w_w_fin  = w_w_sent || w_w_fire;
    assign w_b_fire = r_bready && i_bvalid;

    axilite_chan_src #(.W(ADDR_WIDTH)) u_aw_src (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_accept),
        .i_payload (i_req_addr),
        .i_ready   (i_awready),
        .o_valid   (o_awvalid),
        .o_payload (o_awaddr),
        .o_sent    (w_aw_sent),
        .o_fire    (w_aw_fire)
    );

    axilite_chan_src #(.W(W_PAYLOAD)) u_w_src (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_accept),
        .i_payload ({i_req_strb, i_req_data}),
        .i_ready   (i_wready),
        .o_valid   (o_wvalid),
        .o_payload (w_w_payload),
        .o_sent    (w_w_sent),
        .o_fire    (w_w_fire)
    );

    assign o_wdata     = w_w_payload[DATA_WIDTH-1:0];
    assign o_wstrb     = w_w_payload[W_PAYLOAD-1:DATA_WIDTH];
    assign o_awprot    = AWPROT_DEFAULT;
    assign o_req_ready = r_req_ready;
    assign o_bready    = r_bready;
    assign o_done      = r_done;
    assign o_done_resp = r_done_resp;
    assign o_busy      = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_done_resp <= RESP_OKAY;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // busy stays high through the done cycle unless a new request lands
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_XFER;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_b_fire) begin
                        r_bready    <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_resp <= i_bresp;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_write_initiator.sv
// Bench for the AXI-lite write initiator: directed scenarios plus randomized
// slave timing, checked every cycle against a transaction-level reference model.
module tb_axilite_write_initiator;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    typedef enum {P_IDLE, P_XFER, P_RESP} phase_t;

    logic        clk;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_strb = '0;
    logic        done;
    logic [1:0]  done_resp;
    logic        busy;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    axilite_write_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_req_strb  (req_strb),
        .o_done      (done),
        .o_done_resp (done_resp),
        .o_busy      (busy),
        .o_awaddr    (awaddr),
        .o_awprot    (awprot),
        .o_awvalid   (awvalid),
        .i_awready   (awready),
        .o_wdata     (wdata),
        .o_wstrb     (wstrb),
        .o_wvalid    (wvalid),
        .i_wready    (wready),
        .i_bresp     (bresp),
        .i_bvalid    (bvalid),
        .o_bready    (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // stimulus controls, written by the sequence block
    bit       rst_cmd   = 1'b1;
    bit       noise     = 1'b0;
    bit       rand_mode = 1'b0;
    bit       rand_gap  = 1'b0;
    int       aw_delay  = 0;
    int       w_delay   = 0;
    int       b_delay   = 0;
    logic [1:0] cur_bresp = 2'b00;
    req_t     rq[$];

    // scoreboard state and statistics
    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [1:0]  resp_q[$];
    int cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int n_acc = 0, n_aw = 0, n_w = 0, n_done = 0;
    int acc_cyc = 0, prev_acc_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, done_cyc = 0;
    int aw_hi = 0, w_hi = 0, b_hi = 0;
    logic [1:0]  last_resp = 2'b00;
    logic [31:0] last_awaddr = '0;

    // reference model: what each output must be, from the transaction rules
    phase_t      m_phase     = P_IDLE;
    logic        m_req_ready = 1'b0;
    logic        m_busy      = 1'b0;
    logic        m_aw_pend   = 1'b0;
    logic        m_w_pend    = 1'b0;
    logic        m_bready    = 1'b0;
    logic        m_done      = 1'b0;
    logic [1:0]  m_done_resp = 2'b00;
    logic [31:0] m_awaddr    = '0;
    logic [31:0] m_wdata     = '0;
    logic [3:0]  m_wstrb     = '0;

    always @(negedge clk) begin
        bit present;
        bit acc, aw_hs, w_hs, b_hs;
        cyc = cyc + 1;

        chk("ctrl_outputs", {req_ready, busy, awvalid, wvalid, bready, done, awprot},
            {m_req_ready, m_busy, m_aw_pend, m_w_pend, m_bready, m_done, 3'b000});
        chk("payload_outputs", {awaddr, wdata, wstrb, done_resp},
            {m_awaddr, m_wdata, m_wstrb, m_done_resp});

        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (bready)  b_hi++;
        if (done) begin
            n_done++;
            done_cyc  = cyc;
            last_resp = done_resp;
            $display("txn %0d done: resp=%0d cycle=%0d", n_done, done_resp, cyc);
            chk("done_has_b_handshake", resp_q.size() > 0, 1'b1);
            if (resp_q.size() > 0) chk("done_resp_sb", done_resp, resp_q.pop_front());
        end

        // drive inputs for the next edge
        rst = rst_cmd;
        present = !rst_cmd && rq.size() > 0 && !(rand_gap && $urandom_range(0, 3) == 0);
        if (present) begin
            req_valid = 1'b1;
            {req_addr, req_data, req_strb} = rq[0];
        end else begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_data  = $urandom;
            req_strb  = 4'($urandom);
        end
        awready = awvalid ? (aw_cnt >= aw_delay) : (noise ? 1'($urandom) : 1'b0);
        wready  = wvalid  ? (w_cnt >= w_delay)   : (noise ? 1'($urandom) : 1'b0);
        if (bready) begin
            bvalid = (b_cnt >= b_delay);
            bresp  = cur_bresp;
        end else begin
            bvalid = noise ? 1'($urandom) : 1'b0;
            bresp  = 2'($urandom);
        end
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        w_cnt  = wvalid  ? w_cnt + 1  : 0;
        b_cnt  = bready  ? b_cnt + 1  : 0;

        acc   = req_valid && req_ready && !rst;
        aw_hs = awvalid && awready && !rst;
        w_hs  = wvalid && wready && !rst;
        b_hs  = bvalid && bready && !rst;

        if (rst) begin
            exp_aw_q.delete();
            exp_w_q.delete();
            resp_q.delete();
        end else begin
            if (acc) begin
                exp_aw_q.push_back(req_addr);
                exp_w_q.push_back({req_strb, req_data});
                void'(rq.pop_front());
                n_acc++;
                prev_acc_cyc = acc_cyc;
                acc_cyc = cyc;
                aw_hi = 0; w_hi = 0; b_hi = 0;
                if (rand_mode) begin
                    aw_delay  = $urandom_range(0, 3);
                    w_delay   = $urandom_range(0, 3);
                    b_delay   = $urandom_range(0, 4);
                    cur_bresp = 2'($urandom);
                end
            end
            if (aw_hs) begin
                n_aw++;
                aw_hs_cyc   = cyc;
                last_awaddr = awaddr;
                chk("aw_hs_expected", exp_aw_q.size() > 0, 1'b1);
                if (exp_aw_q.size() > 0) chk("awaddr_sb", awaddr, exp_aw_q.pop_front());
            end
            if (w_hs) begin
                n_w++;
                w_hs_cyc = cyc;
                chk("w_hs_expected", exp_w_q.size() > 0, 1'b1);
                if (exp_w_q.size() > 0) chk("wdata_sb", {wstrb, wdata}, exp_w_q.pop_front());
            end
            if (b_hs) begin
                b_hs_cyc = cyc;
                resp_q.push_back(bresp);
            end
        end

        // advance the model by one edge
        if (rst) begin
            m_phase = P_IDLE; m_req_ready = 1'b0; m_busy = 1'b0;
            m_aw_pend = 1'b0; m_w_pend = 1'b0; m_bready = 1'b0; m_done = 1'b0;
            m_done_resp = 2'b00; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    if (m_req_ready && req_valid) begin
                        m_awaddr = req_addr; m_wdata = req_data; m_wstrb = req_strb;
                        m_aw_pend = 1'b1; m_w_pend = 1'b1;
                        m_busy = 1'b1; m_req_ready = 1'b0; m_phase = P_XFER;
                    end else begin
                        m_req_ready = 1'b1; m_busy = 1'b0;
                    end
                end
                P_XFER: begin
                    if (awready) m_aw_pend = 1'b0;
                    if (wready)  m_w_pend  = 1'b0;
                    if (!m_aw_pend && !m_w_pend) begin
                        m_phase = P_RESP; m_bready = 1'b1;
                    end
                end
                default: begin
                    if (bvalid) begin
                        m_bready = 1'b0; m_done = 1'b1; m_done_resp = bresp;
                        m_req_ready = 1'b1; m_phase = P_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while ((rq.size() != 0 || m_phase != P_IDLE || m_busy) && k < limit) begin
            tick();
            k++;
        end
        chk({name, "_timeout"}, k < limit, 1'b1);
    endtask

    task automatic set_delays(input int a, input int w, input int b, input logic [1:0] r);
        aw_delay = a; w_delay = w; b_delay = b; cur_bresp = r;
    endtask

    initial begin
        int d_done, d_aw, d_w, d_acc;

        // reset behaviour
        tick(2);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_cmd = 1'b0;
        tick();
        chk("req_ready_after_reset", req_ready, 1'b1);

        // zero-wait slave, minimum latency
        set_delays(0, 0, 0, 2'b00);
        d_done = n_done;
        rq.push_back('{addr: 32'h40, data: 32'hDEADBEEF, strb: 4'hF});
        wait_idle("t1", 50);
        chk("t1_awaddr", last_awaddr, 32'h40);
        chk("t1_aw_latency", aw_hs_cyc - acc_cyc, 1);
        chk("t1_b_latency", b_hs_cyc - acc_cyc, 2);
        chk("t1_done_latency", done_cyc - acc_cyc, 3);
        chk("t1_done_resp", last_resp, 2'b00);
        chk("t1_done_count", n_done - d_done, 1);

        // awready late, wready immediate
        set_delays(3, 0, 0, 2'b01);
        rq.push_back('{addr: 32'h1234_5678, data: $urandom, strb: 4'h3});
        wait_idle("t2", 50);
        chk("t2_awvalid_cycles", aw_hi, 4);
        chk("t2_wvalid_cycles", w_hi, 1);
        chk("t2_bready_cycles", b_hi, 1);
        chk("t2_b_after_aw", b_hs_cyc - aw_hs_cyc, 1);

        // W before AW, slow B with SLVERR
        set_delays(2, 0, 5, 2'b10);
        d_done = n_done;
        rq.push_back('{addr: 32'hA0, data: $urandom, strb: 4'hC});
        wait_idle("t3", 50);
        chk("t3_w_first", w_hs_cyc < aw_hs_cyc, 1'b1);
        chk("t3_bready_cycles", b_hi, 6);
        chk("t3_done_count", n_done - d_done, 1);
        chk("t3_done_resp", last_resp, 2'b10);

        // request held high for three back-to-back transactions
        set_delays(0, 0, 0, 2'b00);
        d_done = n_done; d_aw = n_aw; d_w = n_w;
        for (int i = 0; i < 3; i++)
            rq.push_back('{addr: 32'h100 + 32'(i * 4), data: $urandom, strb: 4'hF});
        wait_idle("t4", 60);
        chk("t4_aw_count", n_aw - d_aw, 3);
        chk("t4_w_count", n_w - d_w, 3);
        chk("t4_done_count", n_done - d_done, 3);
        chk("t4_accept_spacing", acc_cyc - prev_acc_cyc, 3);

        // reset in the middle of a transaction
        set_delays(6, 6, 0, 2'b00);
        d_done = n_done;
        rq.push_back('{addr: 32'hBAD0, data: $urandom, strb: 4'hF});
        for (int k = 0; k < 20 && !awvalid; k++) tick();
        chk("t5_awvalid_seen", awvalid, 1'b1);
        rst_cmd = 1'b1;
        tick();
        chk("t5_awvalid_dropped", awvalid, 1'b0);
        chk("t5_wvalid_dropped", wvalid, 1'b0);
        chk("t5_req_ready_in_reset", req_ready, 1'b0);
        rst_cmd = 1'b0;
        tick();
        chk("t5_req_ready_after", req_ready, 1'b1);
        tick(5);
        chk("t5_no_done", n_done - d_done, 0);

        // bvalid noise outside the response phase
        noise = 1'b1;
        d_done = n_done;
        tick(10);
        chk("t6_idle_no_done", n_done - d_done, 0);
        chk("t6_idle_bready", bready, 1'b0);
        set_delays(3, 2, 1, 2'b11);
        rq.push_back('{addr: 32'hC0, data: $urandom, strb: 4'h5});
        wait_idle("t6", 50);
        chk("t6_one_done", n_done - d_done, 1);
        chk("t6_done_resp", last_resp, 2'b11);

        // randomized traffic
        rand_mode = 1'b1;
        rand_gap  = 1'b1;
        d_done = n_done; d_aw = n_aw; d_w = n_w; d_acc = n_acc;
        for (int i = 0; i < 40; i++)
            rq.push_back('{addr: $urandom, data: $urandom, strb: 4'($urandom)});
        wait_idle("rand", 2000);
        chk("rand_accepts", n_acc - d_acc, 40);
        chk("rand_aw_count", n_aw - d_aw, 40);
        chk("rand_w_count", n_w - d_w, 40);
        chk("rand_done_count", n_done - d_done, 40);
        chk("rand_queues_drained", exp_aw_q.size() + exp_w_q.size() + resp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
